// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices needed to cover n bits.
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  // Ripple chain, one cell per bit.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/full_adder.sv
// One-bit full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle with a
// registered carry, valid/ready on both the operand and result sides.
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int unsigned PW     = NCHUNK * CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   a_r, b_r, res_r;
  logic [PW-1:0]   a_ext, b_ext;
  logic            sub_r, carry;
  logic [CW-1:0]   cnt;
  logic [CHUNK-1:0] a_slice, b_slice, s_slice;
  logic            c_out;
  logic [PW:0]     full;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operands zero-padded to a whole number of chunks; B is inverted for
  // subtraction before padding so the pad stays zero and cannot disturb the
  // carry out of bit WIDTH-1.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = op_sub ? ~b : b;
  end

  assign a_slice = a_r[cnt*CHUNK +: CHUNK];
  assign b_slice = b_r[cnt*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_slice),
    .b   (b_slice),
    .cin (carry),
    .s   (s_slice),
    .cout(c_out)
  );

  // Padded result with the current chunk merged in; bit WIDTH is the carry
  // out of bit WIDTH-1 whether or not the last chunk is partial.
  always_comb begin
    full = {c_out, res_r};
    full[cnt*CHUNK +: CHUNK] = s_slice;
  end

  if (PW > WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^full[PW:WIDTH+1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = BUSY;
      BUSY:    if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Operand capture, chunk stepping and result load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a_ext;
          b_r   <= b_ext;
          sub_r <= op_sub;
          carry <= op_sub;
          cnt   <= '0;
        end
        BUSY: begin
          res_r <= full[PW-1:0];
          carry <= c_out;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) sum <= {full[WIDTH] ^ sub_r, full[WIDTH-1:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: three instances (CHUNK=4, 14, 5) at
// WIDTH=14 checked against a plain-arithmetic reference model.
module tb_seq_adder;

  localparam int W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a, b;
  logic         op_sub;
  logic [2:0]   in_valid_v, out_ready_v, in_ready_v, out_valid_v;
  logic [W:0]   sum_v [3];

  int checks = 0;
  int passed = 0;
  int nchunk_of [3] = '{4, 1, 3};

  seq_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum_v[0]));

  seq_adder #(.WIDTH(W), .CHUNK(14)) u_c14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum_v[1]));

  seq_adder #(.WIDTH(W), .CHUNK(5)) u_c5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .sum(sum_v[2]));

  // Reference: a +/- b as a (W+1)-bit two's-complement value.
  function automatic logic [W:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    int r;
    r = s ? (int'(x) - int'(y)) : (int'(x) + int'(y));
    return (W+1)'(r);
  endfunction

  // Drive one operation into instance d and collect its result and latency.
  task automatic do_op(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, output logic [W:0] res, output int lat,
                       output bit tmo);
    int guard;
    guard = 0;
    tmo = 1'b0;
    @(negedge clk);
    a = av; b = bv; op_sub = sv;
    in_valid_v[d] = 1'b1;
    while (!in_ready_v[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) tmo = 1'b1;
    @(posedge clk);
    #1 in_valid_v[d] = 1'b0;
    lat = 0;
    while (!out_valid_v[d] && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 50) tmo = 1'b1;
    res = sum_v[d];
    @(negedge clk);
    out_ready_v[d] = 1'b1;
    @(posedge clk);
    #1 out_ready_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready_v !== 3'b111) $display("FAIL reset_in_ready: got %b expected 111", in_ready_v);
    else passed++;
    checks++;
    if (out_valid_v !== 3'b000) $display("FAIL reset_out_valid: got %b expected 000", out_valid_v);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sum_v[i] !== '0) $display("FAIL reset_sum[%0d]: got %h expected 0", i, sum_v[i]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W:0] r;
    int lat;
    bit tmo;
    do_op(0, 14'd1, 14'd1, 1'b0, r, lat, tmo);
    checks++;
    if (tmo || r !== 15'd2) $display("FAIL basic_sum: got %h expected 0002 (timeout=%0d)", r, tmo);
    else passed++;
    checks++;
    if (lat !== 4) $display("FAIL basic_latency: got %0d expected 4", lat);
    else passed++;
  endtask

  task automatic test_carry();
    logic [W:0] r;
    int lat;
    bit tmo;
    do_op(0, 14'd10, 14'd10, 1'b0, r, lat, tmo);
    checks++;
    if (tmo || r !== 15'd20) $display("FAIL carry_10_10: got %0d expected 20", r);
    else passed++;
    do_op(0, 14'd16383, 14'd16383, 1'b0, r, lat, tmo);
    checks++;
    if (tmo || r !== 15'd32766) $display("FAIL carry_max: got %0d expected 32766", r);
    else passed++;
    checks++;
    if (r[W] !== 1'b1) $display("FAIL carry_msb: got %b expected 1", r[W]);
    else passed++;
  endtask

  task automatic test_sub();
    logic [W:0] r;
    int lat;
    bit tmo;
    do_op(0, 14'd0, 14'd1, 1'b1, r, lat, tmo);
    checks++;
    if (tmo || r !== 15'h7FFF) $display("FAIL sub_0_1: got %h expected 7fff", r);
    else passed++;
    do_op(0, 14'd20, 14'd5, 1'b1, r, lat, tmo);
    checks++;
    if (tmo || r !== 15'd15) $display("FAIL sub_20_5: got %0d expected 15", r);
    else passed++;
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    a = 14'd100; b = 14'd23; op_sub = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    guard = 0;
    while (!out_valid_v[0] && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 50) $display("FAIL bp_wait_valid: got timeout expected out_valid");
    else passed++;
    @(negedge clk);
    a = 14'd7; b = 14'd9; op_sub = 1'b1;
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || sum_v[0] !== 15'd123)
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b sum=%0d expected 1 0 123",
                 i, out_valid_v[0], in_ready_v[0], sum_v[0]);
      else passed++;
    end
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1)
      $display("FAIL bp_take: got valid=%b ready=%b expected 0 1", out_valid_v[0], in_ready_v[0]);
    else passed++;
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready_v[0] !== 1'b1) $display("FAIL bp_no_accept: got in_ready=%b expected 1", in_ready_v[0]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [W:0] r;
    int lat;
    bit tmo;
    bit seen;
    @(negedge clk);
    a = 14'd50; b = 14'd60; op_sub = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || sum_v[0] !== '0)
      $display("FAIL rst_mid: got ready=%b valid=%b sum=%h expected 1 0 0000",
               in_ready_v[0], out_valid_v[0], sum_v[0]);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid_v[0]) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL rst_discard: got out_valid=1 expected 0");
    else passed++;
    do_op(0, 14'd3, 14'd4, 1'b0, r, lat, tmo);
    checks++;
    if (tmo || r !== 15'd7 || lat !== 4)
      $display("FAIL rst_after: got sum=%0d lat=%0d expected 7 4", r, lat);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] e;
    int acc_cyc[$];
    int results;
    int accepts;
    logic [W-1:0] av, bv;
    logic sv;
    results = 0;
    accepts = 0;
    out_ready_v[0] = 1'b1;
    for (int t = 0; t < 60 && results < 3; t++) begin
      @(negedge clk);
      if (out_valid_v[0]) begin
        e = q.pop_front();
        results++;
        checks++;
        if (sum_v[0] !== e) $display("FAIL b2b_sum[%0d]: got %h expected %h", results, sum_v[0], e);
        else passed++;
      end
      if (in_ready_v[0] && accepts < 3) begin
        av = W'($urandom_range(0, 16383));
        bv = W'($urandom_range(0, 16383));
        sv = 1'($urandom_range(0, 1));
        a = av; b = bv; op_sub = sv;
        in_valid_v[0] = 1'b1;
        q.push_back(ref_model(av, bv, sv));
        acc_cyc.push_back(t);
        accepts++;
      end else if (accepts >= 3) begin
        in_valid_v[0] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b0;
    checks++;
    if (results != 3) $display("FAIL b2b_count: got %0d results expected 3", results);
    else passed++;
    if (acc_cyc.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 6)
          $display("FAIL b2b_interval[%0d]: got %0d cycles expected 6", i, acc_cyc[i] - acc_cyc[i-1]);
        else passed++;
      end
    end else begin
      checks++;
      $display("FAIL b2b_accepts: got %0d expected 3", acc_cyc.size());
    end
  endtask

  task automatic test_sweep();
    logic [W:0] r, e;
    logic [W-1:0] av, bv;
    logic sv;
    int lat;
    bit tmo;
    int n;
    for (int d = 0; d < 3; d++) begin
      n = (d == 0) ? 200 : 1000;
      for (int i = 0; i < n; i++) begin
        case (i)
          0: begin av = '0; bv = '1; sv = 1'b1; end
          1: begin av = '1; bv = '1; sv = 1'b0; end
          2: begin av = '1; bv = '0; sv = 1'b1; end
          default: begin
            av = W'($urandom_range(0, 16383));
            bv = W'($urandom_range(0, 16383));
            sv = 1'($urandom_range(0, 1));
          end
        endcase
        e = ref_model(av, bv, sv);
        do_op(d, av, bv, sv, r, lat, tmo);
        checks++;
        if (tmo || r !== e)
          $display("FAIL sweep_sum d=%0d a=%0d b=%0d sub=%0d: got %h expected %h",
                   d, av, bv, sv, r, e);
        else passed++;
        checks++;
        if (lat !== nchunk_of[d])
          $display("FAIL sweep_latency d=%0d: got %0d expected %0d", d, lat, nchunk_of[d]);
        else passed++;
      end
    end
  endtask

  initial begin
    in_valid_v = '0;
    out_ready_v = '0;
    a = '0;
    b = '0;
    op_sub = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
